// File: rtl/door_pkg.sv
// ---------------------------------------------------------------------------
// door_pkg
//   Definitions shared by the door motor driver and the push-button lock FSM:
//   motor FSM state encoding, H-bridge direction constants and a helper that
//   selects the limit switch belonging to a direction.
//   No ports (package).
// ---------------------------------------------------------------------------
package door_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_CW,
    ST_RUN_ACW,
    ST_BRAKE,
    ST_FAULT
  } state_t;

  localparam logic DIR_CW  = 1'b1;  // lock
  localparam logic DIR_ACW = 1'b0;  // unlock

  // Limit switch that ends a move in the given direction.
  function automatic logic limit_reached(input logic dir, input logic locked,
                                         input logic unlocked);
    return (dir == DIR_CW) ? locked : unlocked;
  endfunction

endpackage

// File: rtl/door_motor_driver_if.sv
// ---------------------------------------------------------------------------
// door_motor_driver_if
//   Command/status link between the lock FSM (master) and the motor driver
//   (slave).
//   CMD_CW / CMD_ACW : one-cycle command pulses, master -> slave
//   BUSY, DONE       : move status, slave -> master
//   LOCKED, UNLOCKED : filtered bolt position, slave -> master
//   FAULT            : sticky fault flag, slave -> master
// ---------------------------------------------------------------------------
interface door_motor_driver_if;
  logic CMD_CW;
  logic CMD_ACW;
  logic BUSY;
  logic DONE;
  logic LOCKED;
  logic UNLOCKED;
  logic FAULT;

  modport master (output CMD_CW, CMD_ACW,
                  input  BUSY, DONE, LOCKED, UNLOCKED, FAULT);

  modport slave  (input  CMD_CW, CMD_ACW,
                  output BUSY, DONE, LOCKED, UNLOCKED, FAULT);
endinterface

// File: rtl/door_lim_filter.sv
// ---------------------------------------------------------------------------
// door_lim_filter
//   Conditions one asynchronous limit switch: 2-FF synchronizer, then an
//   optional debounce selected by macro DOOR_LIM_DEBOUNCE_EN. With debounce,
//   the synchronized value must hold a new level for DEB_CYCLES consecutive
//   cycles before filt follows it; without, filt is the synchronizer output.
//   CLK  in  clock
//   RST  in  synchronous active-high reset
//   raw  in  asynchronous switch input
//   filt out filtered switch level
// ---------------------------------------------------------------------------
module door_lim_filter
`ifdef DOOR_LIM_DEBOUNCE_EN
#(
  parameter int DEB_CYCLES = 20000
)
`endif
(
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic filt
);

  logic [1:0] sync;

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge CLK) begin
    if (RST) sync <= '0;
    else     sync <= {sync[0], raw};
  end

`ifdef DOOR_LIM_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // cnt tracks how long the synchronized level has differed from filt;
  // any return to the current level restarts the qualification.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync[1] == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      filt <= sync[1];
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign filt = sync[1];
`endif

endmodule

// File: rtl/door_motor_driver.sv
// ---------------------------------------------------------------------------
// door_motor_driver
//   Receives CW (lock) / ACW (unlock) command pulses and drives the bolt
//   motor H-bridge until the matching limit switch closes, with a run
//   timeout, a brake dead-time after every move or reversal, and sticky
//   fault handling. Optional limit debounce: macro DOOR_LIM_DEBOUNCE_EN.
//   CLK      in   clock
//   RST      in   synchronous active-high reset
//   LIM_LOCK in   async limit switch, 1 = bolt fully locked
//   LIM_UNLK in   async limit switch, 1 = bolt fully unlocked
//   MOT_EN   out  H-bridge enable
//   MOT_DIR  out  1 = CW (lock), 0 = ACW; only changes while MOT_EN = 0
//   cmd_if   slave modport: CMD_CW/CMD_ACW in; BUSY, DONE, LOCKED,
//            UNLOCKED, FAULT out
// ---------------------------------------------------------------------------
module door_motor_driver
  import door_pkg::*;
#(
  parameter int RUN_TIMEOUT  = 1000000,
  parameter int BRAKE_CYCLES = 5000,
  parameter int DEB_CYCLES   = 20000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                LIM_LOCK,
  input  logic                LIM_UNLK,
  output logic                MOT_EN,
  output logic                MOT_DIR,
  door_motor_driver_if.slave  cmd_if
);

  if (RUN_TIMEOUT < 2 || BRAKE_CYCLES < 1 || DEB_CYCLES < 1) begin : g_bad_params
    $error("door_motor_driver: parameter out of range");
  end

  localparam int RUN_W = $clog2(RUN_TIMEOUT + 1);
  localparam int BRK_W = $clog2(BRAKE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_TIMEOUT - 1);
  localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(BRAKE_CYCLES - 1);

  // ---- limit switch conditioning ----
  door_lim_filter
`ifdef DOOR_LIM_DEBOUNCE_EN
    #(.DEB_CYCLES(DEB_CYCLES))
`endif
    u_lim_lock (.CLK(CLK), .RST(RST), .raw(LIM_LOCK), .filt(cmd_if.LOCKED));

  door_lim_filter
`ifdef DOOR_LIM_DEBOUNCE_EN
    #(.DEB_CYCLES(DEB_CYCLES))
`endif
    u_lim_unlk (.CLK(CLK), .RST(RST), .raw(LIM_UNLK), .filt(cmd_if.UNLOCKED));

  // ---- command decode ----
  state_t           state;
  logic [RUN_W-1:0] run_cnt;
  logic [BRK_W-1:0] brk_cnt;
  logic             pend_vld;
  logic             pend_dir;

  logic cw_only, acw_only, both_lim, run_dir, run_hit, rev_cmd;
  logic idle_go, idle_dir, nxt_pend_vld, nxt_pend_dir;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    cw_only      = cmd_if.CMD_CW & ~cmd_if.CMD_ACW;
    acw_only     = cmd_if.CMD_ACW & ~cmd_if.CMD_CW;
    both_lim     = cmd_if.LOCKED & cmd_if.UNLOCKED;
    run_dir      = (state == ST_RUN_CW) ? DIR_CW : DIR_ACW;
    run_hit      = limit_reached(run_dir, cmd_if.LOCKED, cmd_if.UNLOCKED);
    rev_cmd      = (run_dir == DIR_CW) ? acw_only : cw_only;
    idle_go      = 1'b0;
    idle_dir     = DIR_ACW;
    nxt_pend_vld = pend_vld;
    nxt_pend_dir = pend_dir;
    if (cw_only && !cmd_if.LOCKED) begin
      idle_go  = 1'b1;
      idle_dir = DIR_CW;
    end else if (acw_only && !cmd_if.UNLOCKED) begin
      idle_go  = 1'b1;
      idle_dir = DIR_ACW;
    end
    // A lone command during brake replaces the pending move, including one
    // arriving in the final brake cycle.
    if (cw_only) begin
      nxt_pend_vld = 1'b1;
      nxt_pend_dir = DIR_CW;
    end else if (acw_only) begin
      nxt_pend_vld = 1'b1;
      nxt_pend_dir = DIR_ACW;
    end
  end

  // ---- motor FSM with registered outputs ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_IDLE;
      run_cnt       <= '0;
      brk_cnt       <= '0;
      pend_vld      <= 1'b0;
      pend_dir      <= DIR_ACW;
      MOT_EN        <= 1'b0;
      MOT_DIR       <= DIR_ACW;
      cmd_if.BUSY   <= 1'b0;
      cmd_if.DONE   <= 1'b0;
      cmd_if.FAULT  <= 1'b0;
    end else begin
      cmd_if.DONE <= 1'b0;
      if (both_lim) begin
        // Contradictory switches override everything, whatever the state.
        state        <= ST_FAULT;
        MOT_EN       <= 1'b0;
        cmd_if.BUSY  <= 1'b0;
        cmd_if.FAULT <= 1'b1;
        pend_vld     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (idle_go) begin
              state       <= (idle_dir == DIR_CW) ? ST_RUN_CW : ST_RUN_ACW;
              MOT_EN      <= 1'b1;
              MOT_DIR     <= idle_dir;
              cmd_if.BUSY <= 1'b1;
              run_cnt     <= '0;
            end
          end
          ST_RUN_CW, ST_RUN_ACW: begin
            if (run_hit) begin
              state       <= ST_BRAKE;
              MOT_EN      <= 1'b0;
              cmd_if.DONE <= 1'b1;
              brk_cnt     <= '0;
              pend_vld    <= 1'b0;
            end else if (run_cnt == RUN_LAST) begin
              state        <= ST_FAULT;
              MOT_EN       <= 1'b0;
              cmd_if.BUSY  <= 1'b0;
              cmd_if.FAULT <= 1'b1;
            end else if (rev_cmd) begin
              state    <= ST_BRAKE;
              MOT_EN   <= 1'b0;
              brk_cnt  <= '0;
              pend_vld <= 1'b1;
              pend_dir <= ~run_dir;
            end else if (run_cnt != '1) begin
              run_cnt <= run_cnt + 1'b1;
            end
          end
          ST_BRAKE: begin
            pend_vld <= nxt_pend_vld;
            pend_dir <= nxt_pend_dir;
            if (brk_cnt == BRK_LAST) begin
              pend_vld <= 1'b0;
              if (nxt_pend_vld) begin
                state   <= (nxt_pend_dir == DIR_CW) ? ST_RUN_CW : ST_RUN_ACW;
                MOT_EN  <= 1'b1;
                MOT_DIR <= nxt_pend_dir;
                run_cnt <= '0;
              end else begin
                state       <= ST_IDLE;
                cmd_if.BUSY <= 1'b0;
              end
            end else if (brk_cnt != '1) begin
              brk_cnt <= brk_cnt + 1'b1;
            end
          end
          ST_FAULT: begin
            MOT_EN      <= 1'b0;
            cmd_if.BUSY <= 1'b0;
          end
          default: begin
            state        <= ST_FAULT;
            MOT_EN       <= 1'b0;
            cmd_if.BUSY  <= 1'b0;
            cmd_if.FAULT <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_door_motor_driver.sv
// ---------------------------------------------------------------------------
// tb_door_motor_driver
//   Directed bench for door_motor_driver with RUN_TIMEOUT=100,
//   BRAKE_CYCLES=4, DEB_CYCLES=3. Output vectors are packed as
//   {MOT_EN, MOT_DIR, BUSY, DONE, LOCKED, UNLOCKED, FAULT}.
//   Build with DOOR_LIM_DEBOUNCE_EN defined to cover the debounce filter.
// ---------------------------------------------------------------------------
module tb_door_motor_driver;

  localparam int RUN_TIMEOUT  = 100;
  localparam int BRAKE_CYCLES = 4;
  localparam int DEB_CYCLES   = 3;
`ifdef DOOR_LIM_DEBOUNCE_EN
  localparam int LAT = 2 + DEB_CYCLES;  // edges from switch change to LOCKED
`else
  localparam int LAT = 2;
`endif

  logic CLK = 1'b0;
  logic RST;
  logic LIM_LOCK, LIM_UNLK;
  logic MOT_EN, MOT_DIR;
  int   n_cmp = 0;
  int   n_err = 0;

  door_motor_driver_if bus ();

  door_motor_driver #(
    .RUN_TIMEOUT (RUN_TIMEOUT),
    .BRAKE_CYCLES(BRAKE_CYCLES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .LIM_LOCK(LIM_LOCK),
    .LIM_UNLK(LIM_UNLK),
    .MOT_EN  (MOT_EN),
    .MOT_DIR (MOT_DIR),
    .cmd_if  (bus)
  );

  always #5 CLK = ~CLK;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [6:0] exp);
    check(tag, {MOT_EN, MOT_DIR, bus.BUSY, bus.DONE, bus.LOCKED, bus.UNLOCKED,
                bus.FAULT}, exp);
  endtask

  // One-cycle command pulse; returns 1 unit after the sampling edge.
  task automatic pulse(input logic cw, input logic acw);
    bus.CMD_CW  = cw;
    bus.CMD_ACW = acw;
    step(1);
    bus.CMD_CW  = 1'b0;
    bus.CMD_ACW = 1'b0;
  endtask

  initial begin
    RST = 1'b1; LIM_LOCK = 1'b0; LIM_UNLK = 1'b0;
    bus.CMD_CW = 1'b0; bus.CMD_ACW = 1'b0;
    step(3);
    chk_out("reset", 7'b0000000);
    RST = 1'b0;
    step(1);
    chk_out("after_reset", 7'b0000000);

    // Lock move ending on LIM_LOCK.
    pulse(1'b1, 1'b0);
    chk_out("lock_start", 7'b1110000);
    step(18);
    chk_out("lock_running", 7'b1110000);
    LIM_LOCK = 1'b1;
    step(LAT - 1);
    chk_out("lock_filter_pending", 7'b1110000);
    step(1);
    chk_out("lock_filtered", 7'b1110100);
    step(1);
    chk_out("lock_done", 7'b0111100);
    step(1);
    chk_out("brake_1", 7'b0110100);
    step(2);
    chk_out("brake_3", 7'b0110100);
    step(1);
    chk_out("brake_end_idle", 7'b0100100);

    // Redundant and simultaneous commands.
    pulse(1'b1, 1'b0);
    chk_out("redundant_cw", 7'b0100100);
    step(1);
    chk_out("redundant_no_done", 7'b0100100);
    pulse(1'b1, 1'b1);
    chk_out("simultaneous", 7'b0100100);
    step(2);
    chk_out("simultaneous_hold", 7'b0100100);

    LIM_LOCK = 1'b0;
    step(LAT);
    chk_out("unlocked_release", 7'b0100000);

    // Reversal: CW run, ACW mid-move -> 4-cycle brake -> ACW run.
    pulse(1'b1, 1'b0);
    chk_out("rev_cw_start", 7'b1110000);
    step(9);
    pulse(1'b0, 1'b1);
    chk_out("rev_brake", 7'b0110000);
    step(3);
    chk_out("rev_brake_last", 7'b0110000);
    step(1);
    chk_out("rev_acw_run", 7'b1010000);

    // Reset mid-run.
    step(5);
    RST = 1'b1;
    step(1);
    chk_out("rst_mid_run", 7'b0000000);
    RST = 1'b0;
    step(1);

    // Both limits during RUN_CW.
    pulse(1'b1, 1'b0);
    chk_out("both_cw_start", 7'b1110000);
    step(4);
    LIM_LOCK = 1'b1; LIM_UNLK = 1'b1;
    step(LAT);
    chk_out("both_filtered", 7'b1110110);
    step(1);
    chk_out("both_fault", 7'b0100111);
    LIM_LOCK = 1'b0; LIM_UNLK = 1'b0;
    RST = 1'b1;
    step(1);
    chk_out("rst_clears_fault", 7'b0000000);
    RST = 1'b0;
    step(LAT + 1);
    chk_out("idle_after_fault_rst", 7'b0000000);

    // Run timeout: MOT_EN high exactly RUN_TIMEOUT cycles.
    pulse(1'b0, 1'b1);
    chk_out("to_start", 7'b1010000);
    step(RUN_TIMEOUT - 1);
    chk_out("to_last_on", 7'b1010000);
    step(1);
    chk_out("to_fault", 7'b0000001);
    pulse(1'b1, 1'b0);
    chk_out("fault_ignores_cmd", 7'b0000001);
    step(3);
    chk_out("fault_sticky", 7'b0000001);
    RST = 1'b1;
    step(1);
    chk_out("rst_after_timeout", 7'b0000000);
    RST = 1'b0;
    step(1);

`ifdef DOOR_LIM_DEBOUNCE_EN
    // 2-cycle glitch rejected, 3-cycle hold accepted.
    LIM_LOCK = 1'b1;
    step(2);
    LIM_LOCK = 1'b0;
    step(3);
    chk_out("deb_glitch", 7'b0000000);
    step(3);
    chk_out("deb_glitch_settled", 7'b0000000);
    LIM_LOCK = 1'b1;
    step(4);
    chk_out("deb_hold_pending", 7'b0000000);
    step(1);
    chk_out("deb_hold_locked", 7'b0000100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
